// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I-subset CPU with one shared ALU; define RV_MUL_EN to enable mul
module rv_multicycle_core #(
  parameter int          IMEM_WORDS = 32,
  parameter int          DMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc,
  output logic                          retire,
  output logic [31:0]                   wb_data,
  output logic                          halted
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MULX, MEM, WB, HALT} state_t;
  typedef logic [31:0] dmem_t [DMEM_WORDS];
  function automatic dmem_t dmem_init();
    dmem_t d;
    for (int i = 0; i < DMEM_WORDS; i++) d[i] = 32'(i);
    return d;
  endfunction
  state_t state, state_n;
  logic [31:0] imem [IMEM_WORDS];
  dmem_t dmem = dmem_init();
  logic [31:0] x [32];
  logic [31:0] ir, a, b, imm, aluout, mdr, alu, wv;
  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic is_r, is_addi, is_lw, is_sw, is_br, is_mul, legal, lt, taken;
  assign {f7, rs2, rs1, f3, rd, op} = ir;
  assign is_r    = op == 7'h33;
  assign is_addi = op == 7'h13;
  assign is_lw   = op == 7'h03;
  assign is_sw   = op == 7'h23;
  assign is_br   = op == 7'h63;
`ifdef RV_MUL_EN
  assign is_mul  = is_r && f7 == 7'h01 && f3 == 3'b000;
`else
  assign is_mul  = 1'b0;
`endif
  assign legal = (is_r && ((f7 == 7'h00 && f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) || (f7 == 7'h20 && f3 == 3'd0)))
              || is_mul || (is_addi && f3 == 3'd0) || ((is_lw || is_sw) && f3 == 3'd2)
              || (is_br && f3 inside {3'd0, 3'd4, 3'd5});
  assign lt    = $signed(a) < $signed(b);
  assign taken = f3 == 3'd0 ? a == b : f3 == 3'd4 ? lt : !lt;
  assign alu   = !is_r ? a + imm : f3 == 3'd0 ? (f7[5] ? a - b : a + b) : f3 == 3'd7 ? a & b
               : f3 == 3'd6 ? a | b : f3 == 3'd4 ? a ^ b : {31'b0, lt};
  assign wv    = is_lw ? mdr : aluout;
  // state register; reset returns to FETCH and aborts any instruction in flight
  always_ff @(posedge clk)
    state <= !rst ? FETCH : state_n;
  // next-state sequencing plus retire/halt outputs
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = DECODE;
      DECODE:  state_n = EXEC;
      EXEC:    state_n = !legal ? HALT : is_br ? FETCH : (is_lw || is_sw) ? MEM : is_mul ? MULX : WB;
      MULX:    state_n = WB;
      MEM:     state_n = is_lw ? WB : FETCH;
      WB:      state_n = FETCH;
      default: state_n = state;
    endcase
    retire = rst && (state == WB || (state == MEM && is_sw) || (state == EXEC && is_br && legal));
    halted = state == HALT;
  end
  // instruction loading during reset and data stores from MEM
  always_ff @(posedge clk) begin
    if (!rst && imem_we) imem[imem_addr] <= imem_wdata;
    if (rst && state == MEM && is_sw) dmem[aluout[DW+1:2]] <= b;
  end
  // register file; x0 is never written and reads as zero
  always_ff @(posedge clk)
    if (!rst) for (int i = 0; i < 32; i++) x[i] <= '0;
    else if (state == WB && rd != 5'd0) x[rd] <= wv;
  // datapath registers and pc, advanced one FSM step per cycle
  always_ff @(posedge clk)
    if (!rst) begin
      pc      <= RESET_PC;
      wb_data <= '0;
    end else case (state)
      FETCH:  ir <= imem[pc[IW+1:2]];
      DECODE: begin
        a   <= rs1 == 5'd0 ? '0 : x[rs1];
        b   <= rs2 == 5'd0 ? '0 : x[rs2];
        imm <= is_sw ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
             : is_br ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} : {{20{ir[31]}}, ir[31:20]};
      end
      EXEC: if (legal) begin
        aluout <= alu;
        if (is_br) pc <= taken ? pc + imm : pc + 32'd4;
      end
`ifdef RV_MUL_EN
      MULX: aluout <= a * b;
`endif
      MEM: if (is_lw) mdr <= dmem[aluout[DW+1:2]];
           else pc <= pc + 32'd4;
      WB: begin
        wb_data <= wv;
        pc      <= pc + 32'd4;
      end
      default: ;
    endcase
endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: instruction-level model checked every cycle plus literal program results
module tb_rv_multicycle_core;
  logic clk = 0, rst = 0, imem_we = 0;
  logic [4:0] imem_addr = 0;
  logic [31:0] imem_wdata = 0;
  logic [31:0] pc, wb_data;
  logic retire, halted;
  rv_multicycle_core dut (.clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc), .retire(retire), .wb_data(wb_data), .halted(halted));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [31:0] mi [32], md [128], mx [32];
  logic [31:0] m_pc, m_wb;
  bit m_halt, run;
  int c, cyc;
  logic [31:0] obs_pc [256], obs_wb [256];
  bit obs_ret [256], obs_halt [256];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_legal(input logic [31:0] i);
    bit mul_ok = 0;
`ifdef RV_MUL_EN
    mul_ok = i[31:25] == 7'h01 && i[14:12] == 3'd0;
`endif
    case (i[6:0])
      7'h33: return (i[31:25] == 0 && !(i[14:12] inside {3'd1, 3'd3, 3'd5})) || (i[31:25] == 7'h20 && i[14:12] == 0) || mul_ok;
      7'h13: return i[14:12] == 0;
      7'h03, 7'h23: return i[14:12] == 3'd2;
      7'h63: return i[14:12] inside {3'd0, 3'd4, 3'd5};
      default: return 0;
    endcase
  endfunction
  function automatic int m_lat(input logic [31:0] i);
    if (!m_legal(i)) return 3;
    case (i[6:0])
      7'h63: return 3;
      7'h03: return 5;
      7'h33: return i[31:25] == 7'h01 ? 5 : 4;
      default: return 4;
    endcase
  endfunction
  function automatic void m_wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 0) mx[rd] = v;
    m_wb = v;
  endfunction
  function automatic void m_step();
    logic [31:0] i, a, b, ii, is, ib, r, ad;
    bit tk;
    i  = mi[m_pc[6:2]];
    a  = mx[i[19:15]];
    b  = mx[i[24:20]];
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    ib = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    case (i[6:0])
      7'h33: begin
        case (i[14:12])
          3'd0: r = i[31:25] == 7'h01 ? a * b : i[31:25] == 7'h20 ? a - b : a + b;
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd6: r = a | b;
          default: r = a & b;
        endcase
        m_wr(i[11:7], r);
        m_pc += 4;
      end
      7'h13: begin m_wr(i[11:7], a + ii); m_pc += 4; end
      7'h03: begin ad = a + ii; m_wr(i[11:7], md[ad[8:2]]); m_pc += 4; end
      7'h23: begin ad = a + is; md[ad[8:2]] = b; m_pc += 4; end
      default: begin
        tk = i[14:12] == 0 ? a == b : i[14:12] == 4 ? $signed(a) < $signed(b) : $signed(a) >= $signed(b);
        m_pc = tk ? m_pc + ib : m_pc + 4;
      end
    endcase
  endfunction
  always @(negedge clk) begin : cmp
    logic [31:0] ins;
    bit er;
    if (run) begin
      cyc++;
      ins = mi[m_pc[6:2]];
      er = !m_halt && m_legal(ins) && (c + 1 == m_lat(ins));
      if (cyc < 256) begin
        obs_pc[cyc] = pc; obs_wb[cyc] = wb_data; obs_ret[cyc] = retire; obs_halt[cyc] = halted;
      end
      chk("pc", pc, m_pc);
      chk("halted", halted, m_halt);
      chk("retire", retire, er);
      chk("wb_data", wb_data, m_wb);
      if (!m_halt) begin
        c++;
        if (c == m_lat(ins)) begin
          if (m_legal(ins)) m_step(); else m_halt = 1;
          c = 0;
        end
      end
    end
  end
  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1; imem_addr = a[4:0]; imem_wdata = d; mi[a] = d;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_pc"}, pc, 32'h0);
    chk({nm, "_retire"}, retire, 0);
    chk({nm, "_wb"}, wb_data, 0);
    chk({nm, "_halted"}, halted, 0);
  endtask
  task automatic run_prog(input int budget, input bit must_halt, input bit poke);
    int hk = 0;
    @(posedge clk); #2;
    imem_we = 0;
    for (int i = 0; i < 32; i++) mx[i] = 0;
    for (int i = 0; i < 256; i++) begin obs_pc[i] = 'x; obs_wb[i] = 'x; obs_ret[i] = 0; obs_halt[i] = 0; end
    m_pc = 0; m_wb = 0; m_halt = 0; c = 0; cyc = 0;
    rst = 1; run = 1;
    if (poke) begin imem_we = 1; imem_addr = 0; imem_wdata = 32'h00500113; end
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      imem_we = 0;
      if (m_halt) hk++;
      if (hk > 3) break;
    end
    if (must_halt) chk("halt_within_budget", halted, 1);
    run = 0; rst = 0;
    @(posedge clk); @(negedge clk);
    chk_reset("after_reset");
  endtask
  logic [31:0] pa [21] = '{32'h00500113, 32'h00210233, 32'h00402423, 32'h00802283, 32'h00210463,
    32'hFFFFFFFF, 32'h00700013, 32'h20802303, 32'hFFF00213, 32'h00224463, 32'hFFFFFFFF, 32'h00225463,
    32'h00215463, 32'hFFFFFFFF, 32'h00414463, 32'h002223B3, 32'h40410433, 32'h002244B3, 32'h00227533,
    32'h002265B3, 32'hFFFFFFFF};
  initial begin
    for (int i = 0; i < 128; i++) md[i] = i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("init");
    for (int i = 0; i < 32; i++) load(i, 32'hFFFFFFFF);
    for (int i = 0; i < 21; i++) load(i, pa[i]);
    run_prog(300, 1, 0);
    chk("A_ret_c3", obs_ret[3], 0);
    chk("A_ret_c4", obs_ret[4], 1);
    chk("A_ret_c8", obs_ret[8], 1);
    chk("A_addi_wb", obs_wb[5], 32'd5);
    chk("A_add_wb", obs_wb[9], 32'd10);
    chk("A_lw_wb", obs_wb[18], 32'd10);
    chk("A_beq_pc_before", obs_pc[20], 32'h10);
    chk("A_beq_pc", obs_pc[21], 32'h18);
    chk("A_x0_wb", obs_wb[25], 32'd7);
    chk("A_lw_wrap", obs_wb[30], 32'd10);
    chk("A_neg1", obs_wb[34], 32'hFFFFFFFF);
    chk("A_blt_taken", obs_pc[37], 32'h2C);
    chk("A_bge_not", obs_pc[40], 32'h30);
    chk("A_bge_eq", obs_pc[43], 32'h38);
    chk("A_blt_not", obs_pc[46], 32'h3C);
    chk("A_slt", obs_wb[50], 32'd1);
    chk("A_sub", obs_wb[54], 32'd6);
    chk("A_xor", obs_wb[58], 32'hFFFFFFFA);
    chk("A_and", obs_wb[62], 32'd5);
    chk("A_or", obs_wb[66], 32'hFFFFFFFF);
    chk("A_halt_c68", obs_halt[68], 0);
    chk("A_halt_c69", obs_halt[69], 1);
    chk("A_halt_pc", obs_pc[69], 32'h50);
    load(0, 32'h00500113); load(1, 32'h00210233); load(2, 32'h02410333); load(3, 32'hFFFFFFFF);
    run_prog(60, 1, 0);
`ifdef RV_MUL_EN
    chk("B_mul_ret_c12", obs_ret[12], 0);
    chk("B_mul_ret_c13", obs_ret[13], 1);
    chk("B_mul_wb", obs_wb[14], 32'd50);
`else
    chk("B_mul_halt_c11", obs_halt[11], 0);
    chk("B_mul_halt_c12", obs_halt[12], 1);
    chk("B_mul_pc", obs_pc[12], 32'h8);
`endif
    load(0, 32'hFFFFFFFF);
    run_prog(40, 1, 1);
    chk("C_halt_c3", obs_halt[3], 0);
    chk("C_halt_c4", obs_halt[4], 1);
    chk("C_pc", obs_pc[4], 32'h0);
    run_prog(40, 1, 0);
    chk("C_we_ignored", obs_halt[4], 1);
    load(0, 32'h00500113); load(1, 32'h04D00213); load(2, 32'h00402623);
    run_prog(11, 0, 0);
    chk("D_addi77", obs_wb[9], 32'd77);
    load(0, 32'h00C02283); load(1, 32'hFFFFFFFF);
    run_prog(40, 1, 0);
    chk("E_sw_aborted", obs_wb[6], 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
